alu_core: RTL and testbench

Registered 32-bit signed arithmetic/logic unit for the simple microprocessor datapath. It sits between the register-file read ports and the register-file write-back. A 6-bit opcode selects one of eleven operations on two signed 32-bit operands. The result is registered once and returned with a valid strobe.

---
 rtl/alu_core_if.sv | 40 ++++
 rtl/alu_core.sv | 130 +++++++++++++
 tb/tb_alu_core.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_core_if.sv
// alu_core_if: operand/opcode request and registered result bundle for alu_core.
// Optional flag signals (zero, negative, overflow) exist only when the
// ALU_FLAGS_EN macro is defined.
//
// Handshake: in_valid qualifies opcode/a/b for the rising edge it is high on;
// there is no ready, so every valid request is accepted. out_valid is high for
// exactly the one cycle following that edge and qualifies result, illegal_op
// and the flags. Between valid cycles those outputs hold their last value.
interface alu_core_if;
   logic        in_valid;
   logic [5:0]  opcode;
   logic [31:0] a;
   logic [31:0] b;
   logic [31:0] result;
   logic        out_valid;
   logic        illegal_op;
`ifdef ALU_FLAGS_EN
   logic        zero;
   logic        negative;
   logic        overflow;
`endif

   // Requester side: issues operations, observes results.
   modport master (
      output in_valid, opcode, a, b,
`ifdef ALU_FLAGS_EN
      input  zero, negative, overflow,
`endif
      input  result, out_valid, illegal_op
   );

   // ALU side: consumes operations, returns registered results.
   modport slave (
      input  in_valid, opcode, a, b,
`ifdef ALU_FLAGS_EN
      output zero, negative, overflow,
`endif
      output result, out_valid, illegal_op
   );
endinterface

// File: rtl/alu_core.sv
// alu_core: registered 32-bit signed ALU, eleven operations selected by a
// 6-bit opcode, one-cycle latency, one operation per cycle, no backpressure.
// Define ALU_FLAGS_EN to add registered zero/negative/overflow flags.
module alu_core (
   input  logic       clk,
   input  logic       rst_n,
   alu_core_if.slave  bus
);

   localparam logic [5:0] OP_NOP = 6'h00;
   localparam logic [5:0] OP_NOT = 6'h02;
   localparam logic [5:0] OP_MAX = 6'h03;
   localparam logic [5:0] OP_AND = 6'h04;
   localparam logic [5:0] OP_ADD = 6'h05;
   localparam logic [5:0] OP_MIN = 6'h06;
   localparam logic [5:0] OP_NEG = 6'h07;
   localparam logic [5:0] OP_SUB = 6'h08;
   localparam logic [5:0] OP_AVG = 6'h0A;
   localparam logic [5:0] OP_XOR = 6'h0C;
   localparam logic [5:0] OP_ABS = 6'h0D;
   localparam logic [5:0] OP_OR  = 6'h0F;

   localparam logic [31:0] MOST_NEG = 32'h8000_0000;

   // Shared arithmetic terms; several opcodes (and the overflow flag) reuse them.
   logic [31:0]        add_res;
   logic [31:0]        sub_res;
   logic [31:0]        neg_res;
   logic signed [32:0] avg_sum;
   logic               a_gt_b;

   assign add_res = bus.a + bus.b;
   assign sub_res = bus.a - bus.b;
   assign neg_res = 32'd0 - bus.a;
   // Sign-extended 33-bit sum: bits [32:1] are the floor average and can never wrap.
   assign avg_sum = $signed({bus.a[31], bus.a}) + $signed({bus.b[31], bus.b});
   assign a_gt_b  = $signed(bus.a) > $signed(bus.b);

   // The dropped half-bit of the average is intentionally discarded.
   logic unused_avg_lsb;
   assign unused_avg_lsb = avg_sum[0];

   logic [31:0] nxt_result;
   logic        nxt_illegal;

   // Combinational datapath: one case on opcode picks the result and legality.
   always_comb begin
      nxt_result  = '0;
      nxt_illegal = 1'b0;
      case (bus.opcode)
         OP_NOP: nxt_result = '0;
         OP_NOT: nxt_result = ~bus.a;
         OP_MAX: nxt_result = a_gt_b ? bus.a : bus.b;
         OP_AND: nxt_result = bus.a & bus.b;
         OP_ADD: nxt_result = add_res;
         OP_MIN: nxt_result = a_gt_b ? bus.b : bus.a;
         OP_NEG: nxt_result = neg_res;
         OP_SUB: nxt_result = sub_res;
         OP_AVG: nxt_result = avg_sum[32:1];
         OP_XOR: nxt_result = bus.a ^ bus.b;
         // The most negative value has no positive twin; it maps to itself.
         OP_ABS: nxt_result = bus.a[31] ? neg_res : bus.a;
         OP_OR:  nxt_result = bus.a | bus.b;
         default: begin
            nxt_result  = '0;
            nxt_illegal = 1'b1;
         end
      endcase
   end

   logic [31:0] result_q;
   logic        valid_q;
   logic        illegal_q;

   // Output register: result/illegal_op capture only on valid, out_valid tracks in_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         result_q  <= '0;
         valid_q   <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         valid_q <= bus.in_valid;
         if (bus.in_valid) begin
            result_q  <= nxt_result;
            illegal_q <= nxt_illegal;
         end
      end
   end

   assign bus.result     = result_q;
   assign bus.out_valid  = valid_q;
   assign bus.illegal_op = illegal_q;

`ifdef ALU_FLAGS_EN
   logic nxt_overflow;
   logic zero_q;
   logic negative_q;
   logic overflow_q;

   // Signed overflow: ADD/SUB by operand/result sign rule, NEG/ABS only for the most negative value.
   always_comb begin
      nxt_overflow = 1'b0;
      case (bus.opcode)
         OP_ADD: nxt_overflow = (bus.a[31] == bus.b[31]) && (add_res[31] != bus.a[31]);
         OP_SUB: nxt_overflow = (bus.a[31] != bus.b[31]) && (sub_res[31] != bus.a[31]);
         OP_NEG: nxt_overflow = (bus.a == MOST_NEG);
         OP_ABS: nxt_overflow = (bus.a == MOST_NEG);
         default: nxt_overflow = 1'b0;
      endcase
   end

   // Flag register: captured alongside result, held while in_valid is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_q     <= 1'b0;
         negative_q <= 1'b0;
         overflow_q <= 1'b0;
      end else if (bus.in_valid) begin
         zero_q     <= (nxt_result == 32'd0);
         negative_q <= nxt_result[31];
         overflow_q <= nxt_overflow;
      end
   end

   assign bus.zero     = zero_q;
   assign bus.negative = negative_q;
   assign bus.overflow = overflow_q;
`endif

endmodule

// File: tb/tb_alu_core.sv
// tb_alu_core: directed vectors plus randomized back-to-back traffic for
// alu_core, checked against an arithmetic reference model.
// Flag checks are compiled in when ALU_FLAGS_EN is defined.
module tb_alu_core;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;

   logic [31:0] exp_q[$];
   logic [3:0]  side_q[$];   // {illegal, zero, negative, overflow}

   alu_core_if u_if();

   alu_core dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if.slave)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- reference model ----------------
   function automatic bit model_illegal(input logic [5:0] op);
      case (op)
         6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
         6'h07, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F: return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   // Exact mathematical value (before wrapping to 32 bits).
   function automatic longint model_exact(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         6'h02: return ~sa;
         6'h03: return (sa > sb) ? sa : sb;
         6'h04: return sa & sb;
         6'h05: return sa + sb;
         6'h06: return (sa < sb) ? sa : sb;
         6'h07: return -sa;
         6'h08: return sa - sb;
         6'h0A: return (sa + sb) >>> 1;
         6'h0C: return sa ^ sb;
         6'h0D: return (sa < 0) ? -sa : sa;
         6'h0F: return sa | sb;
         default: return 0;
      endcase
   endfunction

   function automatic logic [31:0] model_result(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      longint r;
      r = model_exact(op, a, b);
      return r[31:0];
   endfunction

   function automatic bit model_overflow(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      longint r;
      r = model_exact(op, a, b);
      if (op == 6'h05 || op == 6'h07 || op == 6'h08 || op == 6'h0D)
         return (r > 64'sd2147483647) || (r < -64'sd2147483648);
      return 1'b0;
   endfunction

   // ---------------- driver tasks ----------------
   // Called at a falling edge; presents a request and returns at the next falling edge.
   task automatic drive_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
      u_if.in_valid = 1'b1;
      u_if.opcode   = op;
      u_if.a        = a;
      u_if.b        = b;
      @(negedge clk);
   endtask

   task automatic drive_idle();
      u_if.in_valid = 1'b0;
      u_if.opcode   = 6'($urandom);
      u_if.a        = $urandom;
      u_if.b        = $urandom;
      @(negedge clk);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      u_if.in_valid = 1'b0;
      u_if.opcode = '0;
      u_if.a = '0;
      u_if.b = '0;
      @(negedge clk);
      total++;
      if (u_if.result !== 32'd0 || u_if.out_valid !== 1'b0 || u_if.illegal_op !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs: got res=%h v=%b ill=%b expected 0/0/0",
                  u_if.result, u_if.out_valid, u_if.illegal_op);
      end
`ifdef ALU_FLAGS_EN
      total++;
      if ({u_if.zero, u_if.negative, u_if.overflow} !== 3'b000) begin
         bad++;
         $display("FAIL reset_flags: got %b expected 000", {u_if.zero, u_if.negative, u_if.overflow});
      end
`endif
      rst_n = 1'b1;
      drive_idle();
      total++;
      if (u_if.out_valid !== 1'b0) begin
         bad++;
         $display("FAIL post_reset_idle: got v=%b expected 0", u_if.out_valid);
      end
   endtask

   task automatic test_noop();
      drive_op(6'h00, 32'd0, 32'd0);
      total++;
      if (u_if.out_valid !== 1'b1 || u_if.result !== 32'd0 || u_if.illegal_op !== 1'b0) begin
         bad++;
         $display("FAIL noop: got v=%b res=%h ill=%b expected 1/00000000/0",
                  u_if.out_valid, u_if.result, u_if.illegal_op);
      end
   endtask

   typedef struct {
      string       name;
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] r;
      logic        ovf;
   } vec_t;

   task automatic test_directed();
      vec_t v[$];
      v.push_back('{"add",      6'h05, 32'h1208,     32'h2D78, 32'h3F80,     1'b0});
      v.push_back('{"sub",      6'h08, 32'h2D78,     32'h2BF6, 32'h0182,     1'b0});
      v.push_back('{"neg",      6'h07, 32'h1A82,     32'h5555, 32'hFFFFE57E, 1'b0});
      v.push_back('{"abs",      6'h0D, 32'h2BF6,     32'hAAAA, 32'h2BF6,     1'b0});
      v.push_back('{"avg",      6'h0A, 32'h34EC,     32'h3496, 32'h34C1,     1'b0});
      v.push_back('{"max",      6'h03, 32'h1A80,     32'h3090, 32'h3090,     1'b0});
      v.push_back('{"min",      6'h06, 32'h3090,     32'h34EC, 32'h3090,     1'b0});
      v.push_back('{"not",      6'h02, 32'h3496,     32'h1234, 32'hFFFFCB69, 1'b0});
      v.push_back('{"or",       6'h0F, 32'h348E,     32'h2E04, 32'h3E8E,     1'b0});
      v.push_back('{"and",      6'h04, 32'h2E04,     32'h3372, 32'h2200,     1'b0});
      v.push_back('{"xor",      6'h0C, 32'h3372,     32'h0BA6, 32'h38D4,     1'b0});
      v.push_back('{"max_sgn",  6'h03, 32'hFFFFFFFF, 32'h1,    32'h1,        1'b0});
      v.push_back('{"min_sgn",  6'h06, 32'hFFFFFFFF, 32'h1,    32'hFFFFFFFF, 1'b0});
      v.push_back('{"avg_neg",  6'h0A, 32'hFFFFFFFF, 32'h0,    32'hFFFFFFFF, 1'b0});
      v.push_back('{"avg_big",  6'h0A, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0});
      v.push_back('{"abs_min",  6'h0D, 32'h80000000, 32'h0,    32'h80000000, 1'b1});
      v.push_back('{"abs_neg",  6'h0D, 32'hFFFFFFF6, 32'h0,    32'h0000000A, 1'b0});
      v.push_back('{"add_ovf",  6'h05, 32'h7FFFFFFF, 32'h1,    32'h80000000, 1'b1});
      v.push_back('{"sub_ovf",  6'h08, 32'h80000000, 32'h1,    32'h7FFFFFFF, 1'b1});
      v.push_back('{"neg_min",  6'h07, 32'h80000000, 32'h0,    32'h80000000, 1'b1});
      v.push_back('{"sub_zero", 6'h08, 32'h1234,     32'h1234, 32'h0,        1'b0});
      // Vectors are issued back to back; each check sees the previous edge's capture.
      for (int i = 0; i < v.size(); i++) begin
         drive_op(v[i].op, v[i].a, v[i].b);
         total++;
         if (u_if.out_valid !== 1'b1 || u_if.result !== v[i].r || u_if.illegal_op !== 1'b0) begin
            bad++;
            $display("FAIL %s: got v=%b res=%h ill=%b expected 1/%h/0",
                     v[i].name, u_if.out_valid, u_if.result, u_if.illegal_op, v[i].r);
         end
`ifdef ALU_FLAGS_EN
         total++;
         if (u_if.overflow !== v[i].ovf || u_if.zero !== (v[i].r == 32'd0) || u_if.negative !== v[i].r[31]) begin
            bad++;
            $display("FAIL %s_flags: got z=%b n=%b o=%b expected z=%b n=%b o=%b",
                     v[i].name, u_if.zero, u_if.negative, u_if.overflow,
                     (v[i].r == 32'd0), v[i].r[31], v[i].ovf);
         end
`endif
      end
   endtask

   task automatic test_illegal_idle();
      logic [5:0] bad_ops[4];
      bad_ops = '{6'h3F, 6'h01, 6'h09, 6'h10};
      for (int i = 0; i < 4; i++) begin
         drive_op(bad_ops[i], $urandom, $urandom);
         total++;
         if (u_if.out_valid !== 1'b1 || u_if.result !== 32'd0 || u_if.illegal_op !== 1'b1) begin
            bad++;
            $display("FAIL illegal_%h: got v=%b res=%h ill=%b expected 1/00000000/1",
                     bad_ops[i], u_if.out_valid, u_if.result, u_if.illegal_op);
         end
      end
      // A legal op clears illegal_op; then two idle cycles must hold its result.
      drive_op(6'h05, 32'd5, 32'd6);
      total++;
      if (u_if.illegal_op !== 1'b0 || u_if.result !== 32'd11) begin
         bad++;
         $display("FAIL legal_after_illegal: got res=%h ill=%b expected 0000000b/0",
                  u_if.result, u_if.illegal_op);
      end
      for (int i = 0; i < 2; i++) begin
         drive_idle();
         total++;
         if (u_if.out_valid !== 1'b0 || u_if.result !== 32'd11) begin
            bad++;
            $display("FAIL idle_hold_%0d: got v=%b res=%h expected 0/0000000b",
                     i, u_if.out_valid, u_if.result);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0]  legal_ops[12];
      logic [31:0] corner[6];
      logic [5:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] held;
      logic [31:0] exp_r;
      logic [3:0]  exp_s;
      logic [31:0] r;
      bit          valid;
      legal_ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06,
                    6'h07, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F};
      corner = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h80000001};
      held = u_if.result;
      for (int i = 0; i < 400; i++) begin
         valid = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 3) != 0) op = legal_ops[$urandom_range(0, 11)];
         else                           op = 6'($urandom_range(0, 63));
         a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
         b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
         if (valid) begin
            r = model_result(op, a, b);
            exp_q.push_back(r);
            side_q.push_back({model_illegal(op), (r == 32'd0), r[31], model_overflow(op, a, b)});
            drive_op(op, a, b);
         end else begin
            drive_idle();
         end
         if (valid) begin
            exp_r = exp_q.pop_front();
            exp_s = side_q.pop_front();
            held  = exp_r;
            total++;
            if (u_if.out_valid !== 1'b1 || u_if.result !== exp_r || u_if.illegal_op !== exp_s[3]) begin
               bad++;
               $display("FAIL rand_%0d op=%h a=%h b=%h: got v=%b res=%h ill=%b expected 1/%h/%b",
                        i, op, a, b, u_if.out_valid, u_if.result, u_if.illegal_op, exp_r, exp_s[3]);
            end
`ifdef ALU_FLAGS_EN
            total++;
            if ({u_if.zero, u_if.negative, u_if.overflow} !== exp_s[2:0]) begin
               bad++;
               $display("FAIL rand_flags_%0d op=%h a=%h b=%h: got %b expected %b",
                        i, op, a, b, {u_if.zero, u_if.negative, u_if.overflow}, exp_s[2:0]);
            end
`endif
         end else begin
            total++;
            if (u_if.out_valid !== 1'b0 || u_if.result !== held) begin
               bad++;
               $display("FAIL rand_idle_%0d: got v=%b res=%h expected 0/%h",
                        i, u_if.out_valid, u_if.result, held);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      u_if.in_valid = 1'b1;
      u_if.opcode   = 6'h05;
      u_if.a        = 32'h10;
      u_if.b        = 32'h20;
      #7;   // just past the capturing rising edge
      total++;
      if (u_if.out_valid !== 1'b1 || u_if.result !== 32'h30) begin
         bad++;
         $display("FAIL pre_reset_op: got v=%b res=%h expected 1/00000030", u_if.out_valid, u_if.result);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if (u_if.out_valid !== 1'b0 || u_if.result !== 32'd0 || u_if.illegal_op !== 1'b0) begin
         bad++;
         $display("FAIL async_clear: got v=%b res=%h ill=%b expected 0/0/0",
                  u_if.out_valid, u_if.result, u_if.illegal_op);
      end
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      u_if.in_valid = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         total++;
         if (u_if.out_valid !== 1'b0 || u_if.result !== 32'd0) begin
            bad++;
            $display("FAIL after_release_%0d: got v=%b res=%h expected 0/00000000",
                     i, u_if.out_valid, u_if.result);
         end
         drive_idle();
      end
      drive_op(6'h05, 32'd1, 32'd2);
      total++;
      if (u_if.out_valid !== 1'b1 || u_if.result !== 32'd3) begin
         bad++;
         $display("FAIL alive_after_reset: got v=%b res=%h expected 1/00000003", u_if.out_valid, u_if.result);
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_noop();
      test_directed();
      test_illegal_idle();
      test_back_to_back();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
